// File: rtl/io_port_block.sv
// io_port_block: memory-mapped I/O peripheral at 0x1000 with a TX FIFO,
// a prescaled free-running timer and status/control registers.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   DataAddr          byte address (bits [4:2] select the register)
//   WriteData, WET    store data and write enable from the decoder
//   RDIO              combinational read data of the addressed register
//   tx_data/valid     head-of-FIFO byte and FIFO-not-empty
//   tx_ready          consumer accepts tx_data when tx_valid is high
//   irq               level timer-compare interrupt
//
// Register map (offset from 0x1000):
//   0x00 CTRL     bit0 TEN, bit1 FCLR (write-only), bit2 IRQE
//   0x04 STATUS   [3:0] count, 4 empty, 5 full, 6 OVF, 7 WRAP, 8 MATCH
//                 (bits 6..8 write-1-to-clear)
//   0x08 TXDATA   write pushes WriteData[7:0]
//   0x0C TIMER    write loads the counter and clears the prescaler
//   0x10 COMPARE
//
// Optional build macro IO_IRQ_EN: implements COMPARE, MATCH and IRQE/irq.
// Without it COMPARE and IRQE read 0 and irq is tied low.
module io_port_block #(
   parameter int size       = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int PRESC      = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] DataAddr,
   input  logic [size-1:0] WriteData,
   input  logic            WET,
   output logic [size-1:0] RDIO,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

   logic [2:0]      off;
   logic            wr_ctrl, wr_stat, wr_tx, wr_tmr;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   rptr, wptr;
   logic [CW-1:0]   count;
   logic [3:0]      cnt4;
   logic            full, pop, push_ok, ovf_set, fclr;

   logic            ten;
   logic [PW-1:0]   presc;
   logic [size-1:0] timer, timer_inc;
   logic            tick, inc, wrap_set;

   logic            ovf, wrap, match;
   logic            irqe, match_hit;
   logic [size-1:0] compare;

   assign off     = DataAddr[4:2];
   assign wr_ctrl = WET & (off == 3'd0);
   assign wr_stat = WET & (off == 3'd1);
   assign wr_tx   = WET & (off == 3'd2);
   assign wr_tmr  = WET & (off == 3'd3);

   assign full     = (count == CW'(FIFO_DEPTH));
   assign tx_valid = (count != '0);
   assign tx_data  = mem[rptr];
   assign pop      = tx_valid & tx_ready;
   // A push into a full FIFO is still accepted when a pop frees a slot.
   assign push_ok  = wr_tx & (~full | pop);
   assign ovf_set  = wr_tx & full & ~pop;
   assign fclr     = wr_ctrl & WriteData[1];
   assign cnt4     = 4'(count);

   assign tick      = ten & (presc == PW'(PRESC - 1));
   assign inc       = tick & ~wr_tmr;
   assign timer_inc = timer + size'(1);
   assign wrap_set  = inc & (timer == '1);

   always_ff @(posedge clk) begin
      if (reset) begin
         ten   <= 1'b0;
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         presc <= '0;
         timer <= '0;
         ovf   <= 1'b0;
         wrap  <= 1'b0;
         match <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr_ctrl)
            ten <= WriteData[0];

         // FCLR empties the FIFO regardless of a concurrent pop.
         if (fclr) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
         end else begin
            if (push_ok) begin
               mem[wptr] <= WriteData[7:0];
               wptr      <= wptr + AW'(1);
            end
            if (pop)
               rptr <= rptr + AW'(1);
            case ({push_ok, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end

         // Timer write wins over a same-cycle increment.
         if (wr_tmr) begin
            timer <= WriteData;
            presc <= '0;
         end else if (ten) begin
            if (tick) begin
               presc <= '0;
               timer <= timer_inc;
            end else begin
               presc <= presc + PW'(1);
            end
         end

         // Sticky flags: set beats a same-cycle W1C.
         ovf   <= ovf_set   | (ovf   & ~(wr_stat & WriteData[6]));
         wrap  <= wrap_set  | (wrap  & ~(wr_stat & WriteData[7]));
         match <= match_hit | (match & ~(wr_stat & WriteData[8]));
      end
   end

`ifdef IO_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         irqe      <= 1'b0;
         compare   <= '0;
         match_hit <= 1'b0;
      end else begin
         if (wr_ctrl)
            irqe <= WriteData[2];
         if (WET && off == 3'd4)
            compare <= WriteData;
         // Delay by one cycle: MATCH appears the cycle after the timer
         // has taken the compare value.
         match_hit <= inc & (timer_inc == compare);
      end
   end

   assign irq = match & irqe;
`else
   assign irqe      = 1'b0;
   assign compare   = '0;
   assign match_hit = 1'b0;
   assign irq       = 1'b0;
`endif

   always_comb begin
      RDIO = '0;
      case (off)
         3'd0: RDIO[2:0] = {irqe, 1'b0, ten};
         3'd1: RDIO[8:0] = {match, wrap, ovf, full, ~tx_valid, cnt4};
         3'd3: RDIO      = timer;
         3'd4: RDIO      = compare;
         default: RDIO   = '0;
      endcase
   end

   logic unused;
   assign unused = ^{DataAddr[size-1:5], DataAddr[1:0]};

endmodule

// File: tb/tb_io_port_block.sv
// tb_io_port_block: self-checking bench for io_port_block.
// Scoreboard queue holds expected FIFO bytes in push order.
module tb_io_port_block;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] DataAddr;
   logic [31:0] WriteData;
   logic        WET;
   logic [31:0] RDIO;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic       ovf_m = 1'b0;

   always #5 clk = ~clk;

   io_port_block #(.size(32), .FIFO_DEPTH(DEPTH), .PRESC(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .DataAddr  (DataAddr),
      .WriteData (WriteData),
      .WET       (WET),
      .RDIO      (RDIO),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .irq       (irq)
   );

   function automatic logic [31:0] exp_status();
      logic [31:0] e;
      e = 32'(q.size()) & 32'hF;
      if (q.size() == 0)     e |= 32'h10;
      if (q.size() == DEPTH) e |= 32'h20;
      if (ovf_m)             e |= 32'h40;
      return e;
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      WET = 1'b1; DataAddr = a; WriteData = d;
      @(posedge clk); #1;
      WET = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      DataAddr = a;
      @(negedge clk);
      v = RDIO;
   endtask

   task automatic push(input logic [7:0] b);
      wr(32'h1008, {24'h0, b});
      if (q.size() < DEPTH) q.push_back(b);
      else ovf_m = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(posedge clk); #1;
      tx_ready = 1'b1;
      while (q.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
            errors++;
            $display("FAIL drain: valid=%b data=%h expected valid=1 data=%h",
                     tx_valid, tx_data, q[0]);
         end
         void'(q.pop_front());
      end
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: tx_valid=%b expected 0", tx_valid);
      end
      @(posedge clk); #1;
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1; WET = 1'b1; DataAddr = 32'h1008;
      WriteData = 32'hAA; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; WET = 1'b0;
      rd(32'h1004, v);
      checks++;
      if (v !== 32'h10) begin
         errors++;
         $display("FAIL reset_status: got %h expected 00000010", v);
      end
      checks++;
      if (tx_valid !== 1'b0 || irq !== 1'b0 || tx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b irq=%b data=%h expected 0 0 00",
                  tx_valid, irq, tx_data);
      end
      rd(32'h100C, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL reset_timer: got %h expected 00000000", v);
      end
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] v;
      for (int i = 1; i <= 9; i++) push(8'(i));
      rd(32'h1004, v);
      checks++;
      if (v !== 32'h68 || v !== exp_status()) begin
         errors++;
         $display("FAIL ovf_status: got %h expected 00000068", v);
      end
      drain();
      rd(32'h1004, v);
      checks++;
      if (v !== exp_status()) begin
         errors++;
         $display("FAIL ovf_sticky: got %h expected %h", v, exp_status());
      end
      wr(32'h1004, 32'h40);
      ovf_m = 1'b0;
      rd(32'h1004, v);
      checks++;
      if (v !== 32'h10) begin
         errors++;
         $display("FAIL ovf_w1c: got %h expected 00000010", v);
      end
   endtask

   task automatic test_push_pop_full();
      logic [31:0] v;
      for (int i = 0; i < DEPTH; i++) push(8'(8'h11 + i));
      @(posedge clk); #1;
      tx_ready = 1'b1; WET = 1'b1;
      DataAddr = 32'h1008; WriteData = 32'h55;
      @(negedge clk);
      checks++;
      if (tx_data !== q[0]) begin
         errors++;
         $display("FAIL pp_head: got %h expected %h", tx_data, q[0]);
      end
      void'(q.pop_front());
      q.push_back(8'h55);
      @(posedge clk); #1;
      tx_ready = 1'b0; WET = 1'b0;
      rd(32'h1004, v);
      checks++;
      if (v !== 32'h28) begin
         errors++;
         $display("FAIL pp_status: got %h expected 00000028", v);
      end
      drain();
   endtask

   task automatic test_misc_regs();
      logic [31:0] v;
      wr(32'h1014, 32'hFFFFFFFF);
      rd(32'h1014, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL unused_reg: got %h expected 00000000", v);
      end
      rd(32'h1008, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL txdata_read: got %h expected 00000000", v);
      end
      wr(32'h100C, 32'h12345678);
      rd(32'h100F, v);
      checks++;
      if (v !== 32'h12345678) begin
         errors++;
         $display("FAIL timer_rw: got %h expected 12345678", v);
      end
   endtask

   task automatic test_timer();
      logic [31:0] v;
      wr(32'h100C, 32'hFFFFFFFE);
      wr(32'h1000, 32'h1);
      repeat (8) @(posedge clk);
      rd(32'h100C, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL timer_wrap: got %h expected 00000000", v);
      end
      rd(32'h1004, v);
      checks++;
      if ((v & 32'hFF) !== 32'h90) begin
         errors++;
         $display("FAIL wrap_flag: got %h expected low byte 90", v);
      end
      wr(32'h1000, 32'h0);
      repeat (10) @(posedge clk);
      rd(32'h100C, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL timer_hold: got %h expected 00000000", v);
      end
      wr(32'h1004, 32'h180);
      rd(32'h1004, v);
      checks++;
      if (v !== 32'h10) begin
         errors++;
         $display("FAIL wrap_w1c: got %h expected 00000010", v);
      end
   endtask

   task automatic test_fclr();
      logic [31:0] v;
      for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
      @(posedge clk); #1;
      tx_ready = 1'b1; WET = 1'b1;
      DataAddr = 32'h1000; WriteData = 32'h2;
      @(posedge clk); #1;
      WET = 1'b0;
      q.delete();
      rd(32'h1004, v);
      checks++;
      if (v !== 32'h10 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL fclr: status=%h valid=%b expected 00000010 0",
                  v, tx_valid);
      end
      tx_ready = 1'b0;
      rd(32'h1000, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL fclr_readback: got %h expected 00000000", v);
      end
   endtask

   task automatic test_irq();
      logic [31:0] v;
      wr(32'h1010, 32'h5);
      wr(32'h1000, 32'h5);
      wr(32'h100C, 32'h0);
`ifdef IO_IRQ_EN
      begin
         int  n;
         logic seen;
         n = 0;
         seen = 1'b0;
         DataAddr = 32'h100C;
         while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (irq === 1'b1) seen = 1'b1;
         end
         checks++;
         if (!seen || RDIO !== 32'h5) begin
            errors++;
            $display("FAIL irq_rise: seen=%b timer=%h expected 1 00000005",
                     seen, RDIO);
         end
         rd(32'h1010, v);
         checks++;
         if (v !== 32'h5) begin
            errors++;
            $display("FAIL compare_rw: got %h expected 00000005", v);
         end
         wr(32'h1004, 32'h100);
         @(negedge clk);
         checks++;
         if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b expected 0", irq);
         end
         rd(32'h1000, v);
         checks++;
         if (v !== 32'h5) begin
            errors++;
            $display("FAIL ctrl_irqe: got %h expected 00000005", v);
         end
      end
`else
      begin
         int highs;
         highs = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq !== 1'b0) highs++;
         end
         checks++;
         if (highs != 0) begin
            errors++;
            $display("FAIL irq_tied: irq high %0d cycles expected 0", highs);
         end
         rd(32'h1010, v);
         checks++;
         if (v !== 32'h0) begin
            errors++;
            $display("FAIL compare_absent: got %h expected 00000000", v);
         end
         rd(32'h1000, v);
         checks++;
         if (v !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_no_irqe: got %h expected 00000001", v);
         end
      end
`endif
      wr(32'h1000, 32'h0);
   endtask

   initial begin
      reset = 1'b1; WET = 1'b0; tx_ready = 1'b0;
      DataAddr = '0; WriteData = '0;
      test_reset();
      test_fifo_overflow();
      test_push_pop_full();
      test_misc_regs();
      test_timer();
      test_fclr();
      test_irq();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_port_block.md
Name: io_port_block

Overview:
- Memory-mapped I/O peripheral for the data-memory region at address 0x1000 and above.
- Sits directly downstream of the data-memory address decoder:
  - consumes the decoder's WET write enable, plus DataAddr and WriteData from the core;
  - returns RDIO, the read-data input that the decoder selects with muxSelect = 00.
- Provides three functions:
  - a TX FIFO that drains to an external consumer through a valid/ready handshake;
  - a prescaled free-running timer;
  - status and control registers.

Parameters:
- size, 32, data/address width.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- PRESC, 4, timer increments once every PRESC enabled clk cycles; ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- DataAddr  input  size  byte address from the core; only bits [4:2] decode a register.
- WriteData  input  size  store data from the core.
- WET  input  1  write enable for the I/O region, from the decoder.
- RDIO  output  size  combinational read data for the register addressed by DataAddr.
- tx_data  output  8  head-of-FIFO byte.
- tx_valid  output  1  FIFO not empty.
- tx_ready  input  1  consumer accepts tx_data on a cycle where tx_valid & tx_ready.
- irq  output  1  timer compare interrupt, level.

Behaviour:
- Register map (offset = DataAddr[4:2]×4, base 0x1000):
  - 0x00 CTRL, RW: bit0 TEN (timer enable); bit1 FCLR (write-only, reads 0).
  - 0x04 STATUS, R / W1C:
    - [3:0] count;
    - bit4 empty;
    - bit5 full;
    - bit6 OVF (sticky: push attempted while full);
    - bit7 WRAP (sticky: timer wrapped);
    - bit8 MATCH (sticky).
  - 0x08 TXDATA, W: WriteData[7:0] is pushed. Reads return 0.
  - 0x0C TIMER, RW: a write loads the counter and clears the prescaler.
  - 0x10 COMPARE, RW.
  - Offsets 0x14–0x1C: read 0; writes ignored.
- Reads: RDIO is combinational from DataAddr and current state. It is valid whenever addressed; WET does not gate reads.
- Writes take effect at the clk edge where WET = 1.
- Reset: all registers, the FIFO pointers/count and the prescaler clear to 0. Resulting outputs:
  - RDIO reflects the cleared state (STATUS reads 0x10);
  - tx_valid = 0, tx_data = 0, irq = 0.
  - Reset wins over any simultaneous write or pop.
- FIFO:
  - Push occurs when WET and offset = 0x08.
  - Pop occurs when tx_valid & tx_ready.
  - Push and pop in the same cycle: both happen, count unchanged. This includes the full case: a push while full plus a pop is accepted and OVF is not set.
  - Push while full without a pop: data dropped, OVF set.
  - Pop while empty cannot occur, because tx_valid = 0.
  - tx_data is driven from the read pointer. It holds its value while tx_valid & ~tx_ready.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - FCLR written as 1 empties the FIFO next cycle. It overrides a same-cycle push or pop.
- Timer:
  - While TEN = 1, the prescaler counts 0..PRESC-1. At PRESC-1 the timer increments by 1.
  - 0xFFFFFFFF + 1 wraps to 0 and sets WRAP.
  - A TIMER write in the same cycle as an increment: the write wins and the prescaler resets.
  - TEN = 0 freezes both the timer and the prescaler.
- STATUS W1C: writing 1 to bit 6, 7 or 8 clears that bit.
  - If a set event occurs in the same cycle, set wins.
- Word-aligned access only. DataAddr[1:0] is ignored; bits above [4] are not checked (the decoder guarantees the region).

Optional Feature:
- Macro: IO_IRQ_EN.
- Defined:
  - COMPARE register is implemented.
  - When the timer increments to a value equal to COMPARE, MATCH is set the next cycle.
  - irq = MATCH & CTRL bit2 (IRQE, RW).
- Undefined:
  - COMPARE reads 0 and writes are ignored.
  - MATCH stays 0, CTRL bit2 reads 0, and irq is tied to 0.

Test Plan:
- Reset check: assert reset for 2 cycles with WET = 1 writing 0x1008 ← 0xAA. Then read 0x1004 → 0x10, tx_valid = 0, irq = 0.
- FIFO fill/overflow: hold tx_ready = 0 and push 9 bytes 0x01..0x09.
  - STATUS → count 8, full = 1, OVF = 1.
  - Raise tx_ready: tx_data sequence is 0x01..0x08; then tx_valid = 0.
- Simultaneous push/pop when full:
  - FIFO full, tx_ready = 1, push 0x55 → count stays 8, OVF stays 0, 0x55 drains last.
  - Then write 0x1004 ← 0x40 → OVF clears.
- Timer with PRESC = 4:
  - Write 0x100C ← 0xFFFFFFFE, CTRL ← 1. After 8 cycles TIMER reads 0x00000000 and WRAP = 1.
  - Write CTRL ← 0 → TIMER holds.
- FCLR priority: with 3 entries queued, write CTRL ← 0x2 while tx_ready = 1 → next cycle count = 0, tx_valid = 0.
- IO_IRQ_EN: COMPARE ← 5, CTRL ← 0x5, TIMER ← 0.
  - irq rises once the timer reaches 5.
  - Write 0x1004 ← 0x100 → irq falls.
  - Without the macro: irq stays 0 and COMPARE reads 0.
